// File: rtl/input_conditioner.sv
// Five-channel switch/button conditioner: 2-flop synchronizer per input,
// per-bit debounce counter, and a registered change pulse with a change mask.
// Outputs {X,Y,Z,K,M} are fully registered; no raw input reaches an output
// combinationally.
module input_conditioner #(
  parameter int unsigned DB_CYCLES = 4,
  parameter logic [4:0]  RST_VAL   = 5'b00000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       x_raw,
  input  logic       y_raw,
  input  logic       z_raw,
  input  logic       k_raw,
  input  logic       m_raw,
  output logic       X,
  output logic       Y,
  output logic       Z,
  output logic       K,
  output logic       M,
  output logic       chg,
  output logic [4:0] chg_mask
);

  localparam int unsigned   CW       = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DB_CYCLES);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  // Bit order everywhere is [4:0] = {X,Y,Z,K,M}.
  logic [4:0]    raw;
  logic [4:0]    s1_p0;
  logic [4:0]    s2_p1;
  logic [4:0]    stable_p2;
  logic [4:0]    stable_nxt;
  logic [4:0]    chg_mask_p2;
  logic          chg_p2;
  logic [CW-1:0] cnt_p2  [5];
  logic [CW-1:0] cnt_nxt [5];

  // Counter increment that can never wrap, even if the count logic is
  // ever reached with an out-of-range value.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v >= CNT_MAX) ? CNT_MAX : v + CNT_ONE;
  endfunction

  assign raw = {x_raw, y_raw, z_raw, k_raw, m_raw};

  // Stage p0/p1: two-flop synchronizer, runs regardless of en.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_p0 <= RST_VAL;
      s2_p1 <= RST_VAL;
    end else begin
      s1_p0 <= raw;
      s2_p1 <= s1_p0;
    end
  end

  // Next-state debounce decision per bit; en low holds counts and levels.
  always_comb begin
    stable_nxt = stable_p2;
    for (int i = 0; i < 5; i++) begin
      cnt_nxt[i] = cnt_p2[i];
      if (en) begin
        if (s2_p1[i] == stable_p2[i]) begin
          cnt_nxt[i] = '0;
        end else if (cnt_p2[i] == CNT_LAST) begin
          stable_nxt[i] = s2_p1[i];
          cnt_nxt[i]    = '0;
        end else begin
          cnt_nxt[i] = sat_inc(cnt_p2[i]);
        end
      end
    end
  end

  // Stage p2: counters, stable levels and the change pulse update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 5; i++) begin
        cnt_p2[i] <= '0;
      end
      stable_p2   <= RST_VAL;
      chg_mask_p2 <= 5'b00000;
      chg_p2      <= 1'b0;
    end else begin
      for (int i = 0; i < 5; i++) begin
        cnt_p2[i] <= cnt_nxt[i];
      end
      stable_p2   <= stable_nxt;
      chg_mask_p2 <= stable_nxt ^ stable_p2;
      chg_p2      <= |(stable_nxt ^ stable_p2);
    end
  end

  assign X        = stable_p2[4];
  assign Y        = stable_p2[3];
  assign Z        = stable_p2[2];
  assign K        = stable_p2[1];
  assign M        = stable_p2[0];
  assign chg      = chg_p2;
  assign chg_mask = chg_mask_p2;

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner (DB_CYCLES=4, RST_VAL=0).
// Expected change events are queued when stimulus is driven and matched
// against chg pulses by a monitor running on the falling edge.
module tb_input_conditioner;

  localparam int L = 4 + 2;  // raw-to-output latency in edges

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       x_raw, y_raw, z_raw, k_raw, m_raw;
  logic       X, Y, Z, K, M;
  logic       chg;
  logic [4:0] chg_mask;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int         cyc;
    logic [4:0] mask;
    logic [4:0] outs;
  } exp_t;

  exp_t exp_q[$];
  exp_t e_mon;

  input_conditioner #(
    .DB_CYCLES(4),
    .RST_VAL  (5'b00000)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .x_raw   (x_raw),
    .y_raw   (y_raw),
    .z_raw   (z_raw),
    .k_raw   (k_raw),
    .m_raw   (m_raw),
    .X       (X),
    .Y       (Y),
    .Z       (Z),
    .K       (K),
    .M       (M),
    .chg     (chg),
    .chg_mask(chg_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_chg(input int at, input logic [4:0] mask, input logic [4:0] outs);
    exp_t e;
    e.cyc  = at;
    e.mask = mask;
    e.outs = outs;
    exp_q.push_back(e);
  endtask

  function automatic logic [31:0] outs32();
    return {27'd0, X, Y, Z, K, M};
  endfunction

  // Scoreboard monitor: every chg pulse must match the oldest queued event.
  always @(negedge clk) begin
    if (rst_n) begin
      if (chg) begin
        if (exp_q.size() == 0) begin
          check("unexpected_chg", {31'd0, chg}, 32'd0);
        end else begin
          e_mon = exp_q.pop_front();
          check("chg_cycle", cyc, e_mon.cyc);
          check("chg_mask", {27'd0, chg_mask}, {27'd0, e_mon.mask});
          check("chg_outs", outs32(), {27'd0, e_mon.outs});
        end
      end else begin
        check("mask_idle", {27'd0, chg_mask}, 32'd0);
        if (exp_q.size() != 0 && cyc > exp_q[0].cyc) begin
          e_mon = exp_q.pop_front();
          check("missed_chg", {31'd0, chg}, 32'd1);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c;
    int n;
    rst_n = 1'b0;
    en    = 1'b1;
    {x_raw, y_raw, z_raw, k_raw, m_raw} = 5'b00000;

    // Reset state
    step(3);
    check("rst_outs", outs32(), 32'd0);
    check("rst_chg", {31'd0, chg}, 32'd0);
    check("rst_mask", {27'd0, chg_mask}, 32'd0);
    rst_n = 1'b1;
    step(10);
    check("idle_outs", outs32(), 32'd0);

    // Clean edge on X
    c = cyc;
    x_raw = 1'b1;
    expect_chg(c + L, 5'b10000, 5'b10000);
    step(L - 1);
    check("x_before", {31'd0, X}, 32'd0);
    step(1);
    check("x_after", {31'd0, X}, 32'd1);
    check("x_chg", {31'd0, chg}, 32'd1);
    check("x_mask", {27'd0, chg_mask}, 32'h10);
    step(1);
    check("x_pulse_end", {31'd0, chg}, 32'd0);

    // Glitch on K: three cycles high is rejected
    k_raw = 1'b1;
    step(3);
    k_raw = 1'b0;
    step(8);
    check("k_stays", {31'd0, K}, 32'd0);
    check("k_cnt_zero", 32'(dut.cnt_p2[1]), 32'd0);

    // Simultaneous Y and M
    c = cyc;
    y_raw = 1'b1;
    m_raw = 1'b1;
    expect_chg(c + L, 5'b01001, 5'b11001);
    step(L);
    check("ym_outs", outs32(), 32'h19);
    step(2);

    // Enable freeze on Z
    c = cyc;
    z_raw = 1'b1;
    expect_chg(c + 16, 5'b00100, 5'b11101);
    step(4);
    en = 1'b0;
    step(10);
    check("z_frozen", {31'd0, Z}, 32'd0);
    check("z_cnt_held", 32'(dut.cnt_p2[2]), 32'd2);
    en = 1'b1;
    step(1);
    check("z_one_more", {31'd0, Z}, 32'd0);
    step(1);
    check("z_rise", {31'd0, Z}, 32'd1);
    step(2);

    // All set bits fall together
    c = cyc;
    {x_raw, y_raw, z_raw, k_raw, m_raw} = 5'b00000;
    expect_chg(c + L, 5'b11101, 5'b00000);
    step(L + 1);
    check("all_low", outs32(), 32'd0);

    // Reset mid-count on X, with Y already high
    c = cyc;
    y_raw = 1'b1;
    expect_chg(c + L, 5'b01000, 5'b01000);
    step(L + 1);
    x_raw = 1'b1;
    step(3);
    check("x_counting", 32'(dut.cnt_p2[4]), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_outs", outs32(), 32'd0);
    check("async_chg", {31'd0, chg}, 32'd0);
    check("async_mask", {27'd0, chg_mask}, 32'd0);
    check("async_cnt", 32'(dut.cnt_p2[4]), 32'd0);
    y_raw = 1'b0;
    step(2);
    rst_n = 1'b1;
    c = cyc;
    expect_chg(c + L, 5'b10000, 5'b10000);
    step(L - 1);
    check("x_rel_before", {31'd0, X}, 32'd0);
    step(1);
    check("x_rel_after", outs32(), 32'h10);
    step(2);

    // En low while M returns to its stable value: count clears on resume
    m_raw = 1'b1;
    step(4);
    check("m_cnt_two", 32'(dut.cnt_p2[0]), 32'd2);
    en = 1'b0;
    m_raw = 1'b0;
    step(5);
    en = 1'b1;
    step(1);
    check("m_cnt_clear", 32'(dut.cnt_p2[0]), 32'd0);
    check("m_stays", {31'd0, M}, 32'd0);
    step(8);

    // Drain any outstanding expectations within a bounded wait
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      step(1);
      n++;
    end
    check("queue_drained", exp_q.size(), 32'd0);
    step(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
